// File: rtl/aes_lite_pkg.sv
// rtl/aes_lite_pkg.sv - shared types, S-box and round constants for the AES-lite datapath
package aes_lite_pkg;

    // Width of round indices; covers up to 15 rounds, which is enough for the 10-round maximum.
    localparam int IDX_W      = 4;
    localparam int MAX_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        STREAM
    } state_t;

    // 4-bit S-box, entry 0 in the lowest nibble: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    // Round constants are successive xtime steps over 0x11B; round 0 and out-of-range rounds add nothing.
    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1B;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_lite_key_round.sv
// rtl/aes_lite_key_round.sv - one key-expansion step, previous round key to next round key
module aes_lite_key_round
    import aes_lite_pkg::*;
(
    input  logic [7:0]       prev_key,
    input  logic [IDX_W-1:0] round,
    output logic [7:0]       next_key
);

    // Nibbles are substituted and swapped, then the round constant is folded in.
    assign next_key = {sbox4(prev_key[3:0]), sbox4(prev_key[7:4])} ^ rcon(round);

endmodule

// File: rtl/aes_lite_key_sched.sv
// rtl/aes_lite_key_sched.sv - expands an 8-bit key into a buffered schedule and streams it to the core
module aes_lite_key_sched
    import aes_lite_pkg::*;
#(
    parameter int NUM_ROUNDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       key_in,
    input  logic             dir_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             replay,
    output logic [7:0]       rk_data,
    output logic [IDX_W-1:0] rk_index,
    output logic             rk_last,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             key_loaded,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t           state;
    logic             dir;
    logic [IDX_W-1:0] exp_idx;
    logic [IDX_W-1:0] str_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] end_idx;
    logic [7:0]       next_key;

    // Sized to the full index space so any 4-bit index is a legal address; only 0..NUM_ROUNDS are used.
    logic [7:0] key_buf [2**IDX_W];

    aes_lite_key_round u_round (
        .prev_key (key_buf[exp_idx - ONE]),
        .round    (exp_idx),
        .next_key (next_key)
    );

    // Stream walks up for encryption and down for decryption; the end index stops it, so no wrap occurs.
    always_comb begin
        nxt_idx = dir ? (str_idx - ONE) : (str_idx + ONE);
        end_idx = dir ? '0 : LAST_IDX;
    end

    // Schedule buffer: key written on load, one expanded key per EXPAND cycle; contents need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && load_valid) begin
            key_buf[0] <= key_in;
        end else if (state == EXPAND) begin
            key_buf[exp_idx] <= next_key;
        end
    end

    // Control FSM with registered stream outputs; STREAM spends its first cycle priming rk_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir        <= 1'b0;
            exp_idx    <= '0;
            str_idx    <= '0;
            rk_data    <= 8'h00;
            rk_index   <= '0;
            rk_last    <= 1'b0;
            rk_valid   <= 1'b0;
            key_loaded <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        // A load outranks a simultaneous replay: the old schedule is discarded.
                        dir        <= dir_in;
                        key_loaded <= 1'b0;
                        exp_idx    <= ONE;
                        state      <= EXPAND;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                    end else if (replay && key_loaded) begin
                        dir        <= dir_in;
                        str_idx    <= dir_in ? LAST_IDX : '0;
                        state      <= STREAM;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                EXPAND: begin
                    if (exp_idx == LAST_IDX) begin
                        key_loaded <= 1'b1;
                        str_idx    <= dir ? LAST_IDX : '0;
                        state      <= STREAM;
                    end else begin
                        exp_idx <= exp_idx + ONE;
                    end
                end
                STREAM: begin
                    if (!rk_valid) begin
                        rk_data  <= key_buf[str_idx];
                        rk_index <= str_idx;
                        rk_last  <= (str_idx == end_idx);
                        rk_valid <= 1'b1;
                    end else if (rk_ready) begin
                        if (rk_last) begin
                            rk_valid   <= 1'b0;
                            rk_last    <= 1'b0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                        end else begin
                            str_idx  <= nxt_idx;
                            rk_data  <= key_buf[nxt_idx];
                            rk_index <= nxt_idx;
                            rk_last  <= (nxt_idx == end_idx);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    rk_valid   <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_lite_key_sched.sv
// tb/tb_aes_lite_key_sched.sv - directed self-checking bench for the round-key scheduler
module tb_aes_lite_key_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = 8'h00;
    logic       dir_in = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       replay = 1'b0;
    logic [7:0] rk_data;
    logic [3:0] rk_index;
    logic       rk_last;
    logic       rk_valid;
    logic       rk_ready = 1'b1;
    logic       key_loaded;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    aes_lite_key_sched #(.NUM_ROUNDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .dir_in     (dir_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .replay     (replay),
        .rk_data    (rk_data),
        .rk_index   (rk_index),
        .rk_last    (rk_last),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .key_loaded (key_loaded),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rk_valid"}, rk_valid, 0);
        check({tag, " rk_data"}, rk_data, 0);
        check({tag, " rk_index"}, rk_index, 0);
        check({tag, " rk_last"}, rk_last, 0);
        check({tag, " key_loaded"}, key_loaded, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " load_ready"}, load_ready, 1);
    endtask

    // Ends at the negedge just after the accepting edge (edge 0).
    task automatic start_load(input logic [7:0] k, input logic d, input logic with_replay);
        @(negedge clk);
        key_in     = k;
        dir_in     = d;
        load_valid = 1'b1;
        replay     = with_replay;
        @(negedge clk);
        load_valid = 1'b0;
        replay     = 1'b0;
        check("load busy", busy, 1);
        check("load load_ready", load_ready, 0);
        check("load key_loaded", key_loaded, 0);
        check("load rk_valid", rk_valid, 0);
    endtask

    task automatic start_replay(input logic d);
        @(negedge clk);
        dir_in = d;
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        check("replay busy", busy, 1);
        check("replay rk_valid", rk_valid, 0);
    endtask

    // Counts edges after edge 0 until rk_valid is seen; a blown bound shows up as a wrong latency.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!rk_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!rk_valid && lat < exp_lat) check({tag, " busy while waiting"}, busy, 1);
        end
        check({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic run_stream(input string tag, input logic [39:0] keys, input logic d,
                              input int stall_k, input int pulse_k);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] ek;
            logic [3:0] ei;
            ek = keys[39 - 8*k -: 8];
            ei = d ? 4'(4 - k) : 4'(k);
            check({tag, " valid"}, rk_valid, 1);
            check({tag, " data"}, rk_data, ek);
            check({tag, " index"}, rk_index, ei);
            check({tag, " last"}, rk_last, (k == 4));
            if (k == pulse_k) begin
                load_valid = 1'b1;
                key_in     = 8'hFF;
                check({tag, " load_ready in stream"}, load_ready, 0);
            end
            if (k == stall_k) begin
                rk_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check({tag, " stall valid"}, rk_valid, 1);
                    check({tag, " stall data"}, rk_data, ek);
                    check({tag, " stall index"}, rk_index, ei);
                end
                rk_ready = 1'b1;
            end
            @(negedge clk);
            load_valid = 1'b0;
        end
        check({tag, " end valid"}, rk_valid, 0);
        check({tag, " end busy"}, busy, 0);
        check({tag, " end load_ready"}, load_ready, 1);
    endtask

    task automatic replay_ignored(input string tag);
        @(negedge clk);
        dir_in = 1'b0;
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, " no valid"}, rk_valid, 0);
        check({tag, " no busy"}, busy, 0);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Forward stream of key 0x55.
        start_load(8'h55, 1'b0, 1'b0);
        wait_valid("fwd55", 5);
        run_stream("fwd55", 40'h55_01_5E_14_9D, 1'b0, -1, -1);
        check("fwd55 key_loaded", key_loaded, 1);

        // Reverse stream of key 0x00.
        start_load(8'h00, 1'b1, 1'b0);
        wait_valid("rev00", 5);
        run_stream("rev00", 40'hE7_A9_76_CD_00, 1'b1, -1, -1);

        // Back-pressure at index 2.
        start_load(8'h55, 1'b0, 1'b0);
        wait_valid("stall", 5);
        run_stream("stall", 40'h55_01_5E_14_9D, 1'b0, 2, -1);

        // Load attempt during stream must be ignored, then reverse replay.
        start_load(8'h55, 1'b0, 1'b0);
        wait_valid("ignload", 5);
        run_stream("ignload", 40'h55_01_5E_14_9D, 1'b0, -1, 1);
        check("ignload key_loaded", key_loaded, 1);
        start_replay(1'b1);
        wait_valid("replay", 1);
        run_stream("replay", 40'h9D_14_5E_01_55, 1'b1, -1, -1);

        // Asynchronous reset in the middle of expansion.
        start_load(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst expand");
        @(negedge clk);
        rst = 1'b0;
        replay_ignored("rst expand replay");

        // Asynchronous reset at index 3 of a stream.
        start_load(8'h55, 1'b0, 1'b0);
        wait_valid("rst stream", 5);
        repeat (3) @(negedge clk);
        check("rst stream pre index", rk_index, 3);
        check("rst stream pre data", rk_data, 8'h14);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst stream");
        @(negedge clk);
        rst = 1'b0;
        replay_ignored("rst stream replay");

        // Load and replay together: the load wins and expands afresh.
        start_load(8'h00, 1'b0, 1'b1);
        wait_valid("loadwins", 5);
        run_stream("loadwins", 40'h00_CD_76_A9_E7, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
